ram_sync_block: RTL
===================

# ram_sync_block

Synchronous single-port data RAM with self-clearing initialisation, for the microprocessor datapath where the combinational RAM block is no longer adequate. It has a registered read with a one-cycle `rvalid` strobe and defined read-during-write behaviour. It also range-checks addresses and can re-clear its contents on command. It sits between the memory address/data registers and the control unit, which must wait for `ready` before issuing accesses.

## Interface
- `adlines`, 8: address width in bits.
- `datalines`, 8: data word width in bits.
- `ramsize`, 256: number of words; legal range 2..2^adlines.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `address`  in  adlines  word address for the current request.
- `datain`  in  datalines  write data.
- `read`  in  1  read request, sampled at the edge.
- `write`  in  1  write request, sampled at the edge.
- `clear`  in  1  request a re-initialisation of all words to 0.
- `dataout`  out  datalines  registered read data; 0 whenever `rvalid`=0.
- `rvalid`  out  1  one-cycle strobe; `dataout` is valid in that cycle.
- `ready`  out  1  high when the block accepts requests.
- `err`  out  1  one-cycle strobe; the previously accepted request had `address` >= `ramsize`.

## Operation
- The FSM has two states, INIT and RUN.
- Reset value is INIT, with clear counter = 0, `ready`=0, `rvalid`=0, `dataout`=0, `err`=0.
- INIT:
  - Each edge writes 0 to memory[counter] and increments counter.
  - On the edge that clears word `ramsize`-1, go to RUN; counter returns to 0.
  - `read`, `write` and `clear` are ignored; no `rvalid` and no `err` are produced.
- RUN, on an edge with `ready`=1:
  - `clear`=1: go to INIT. `clear` has priority; `read`/`write` in the same cycle are dropped.
  - `write`=1 with an in-range address: memory[address] <= `datain`.
  - `read`=1 with an in-range address: next cycle `dataout` = memory[address], `rvalid`=1.
  - `read` and `write` together at the same address: read-first. `dataout` returns the old contents; the new value is stored.
  - Out-of-range address (address >= `ramsize`), on read, write or both:
    - The memory is untouched.
    - `err`=1 next cycle.
    - A read additionally gives `rvalid`=1 with `dataout`=0.
- A read accepted on the same edge that `clear` is seen in the following cycle cannot occur, because `clear` drops requests. An `rvalid` already in flight from the previous edge still completes normally during the first INIT cycle.
- Arithmetic: the counter is ceil(log2(ramsize)) bits minimum, and the comparison is unsigned. No wrap-around: INIT ends exactly at `ramsize`-1.

## Timing
- Init latency after `rst_n` rises: `ready` goes high after exactly `ramsize` rising edges (counted from the first edge with `rst_n`=1).
- `clear` latency: `ready` falls in the cycle after the edge that sampled `clear`, then rises after `ramsize` further edges.
- Read latency is 1 cycle: request sampled at edge N, so `dataout`/`rvalid` are valid in the cycle following edge N. Back-to-back reads give `rvalid` high continuously.
- Write latency is 0: a read at edge N+1 sees a write from edge N.
- `rvalid`, `err`, `dataout` and `ready` are all registered outputs; none of them is combinational from the inputs.
- `rst_n` asserted at any time, including mid-INIT or mid-read:
  - All outputs go to their reset values immediately (asynchronously).
  - The FSM returns to INIT with counter 0.
  - Memory contents are not guaranteed until the new INIT completes.

## Test plan
- Reset/init, with `ramsize`=16: release `rst_n` -> `ready`=0 for 16 edges, then 1. Reads of addresses 0..15 each return 0 with `rvalid` one cycle later.
- Write/read: write 0xA5 to address 3, then read address 3 on the next edge -> `dataout`=0xA5, `rvalid`=1 one cycle after the read edge; `dataout`=0 in the cycle after that.
- Read-during-write: address 7 holds 0x11; assert `read`=1 and `write`=1 with `datain`=0x22 at address 7 -> `dataout`=0x11. A subsequent read returns 0x22.
- Out-of-range, with `adlines`=8 and `ramsize`=200:
  - Write 0xFF to address 210 -> `err` pulses, memory is unchanged.
  - Read address 210 -> `rvalid`=1, `dataout`=0, `err`=1.
- Clear: fill addresses 0..15 with nonzero data, then assert `clear` together with `write` -> the write is dropped and `ready`=0 for 16 cycles. Afterwards all reads return 0.
- Reset mid-init: assert `rst_n`=0 at init cycle 5, release it -> all outputs are 0 immediately, and `ready` rises a full 16 edges after the release.

Source files
------------

// File: rtl/ram_sync_block.sv
// ram_sync_block: synchronous single-port data RAM with self-clearing init,
// registered read (one-cycle rvalid strobe), read-first on read/write
// collision, address range checking and on-demand re-clear.
module ram_sync_block #(
  parameter int unsigned adlines   = 8,
  parameter int unsigned datalines = 8,
  parameter int unsigned ramsize   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [adlines-1:0]   address,
  input  logic [datalines-1:0] datain,
  input  logic                 read,
  input  logic                 write,
  input  logic                 clear,
  output logic [datalines-1:0] dataout,
  output logic                 rvalid,
  output logic                 ready,
  output logic                 err
);

  localparam int unsigned cw  = (ramsize > 1) ? $clog2(ramsize) : 1;
  localparam int unsigned aw1 = adlines + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [cw-1:0]        cnt_q, cnt_d;
  logic [datalines-1:0] mem [ramsize];

  logic [datalines-1:0] dataout_d;
  logic                 rvalid_d;
  logic                 ready_d;
  logic                 err_d;

  logic                 in_range_c;
  logic                 mem_we_c;
  logic [adlines-1:0]   mem_addr_c;
  logic [datalines-1:0] mem_wdata_c;

  // Unsigned range check, one bit wider so ramsize == 2^adlines is representable
  assign in_range_c = ({1'b0, address} < aw1'(ramsize));

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      dataout <= '0;
      rvalid  <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dataout <= dataout_d;
      rvalid  <= rvalid_d;
      ready   <= ready_d;
      err     <= err_d;
    end
  end

  // Next-state, memory write control and next output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dataout_d   = '0;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = address;
    mem_wdata_c = datain;

    case (state_q)
      INIT: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = adlines'(cnt_q);
        mem_wdata_c = '0;
        if (cnt_q == cw'(ramsize - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + cw'(1);
        end
      end
      RUN: begin
        if (clear) begin
          // clear wins; any read/write this cycle is dropped
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          mem_we_c = write & in_range_c;
          rvalid_d = read;
          err_d    = (read | write) & ~in_range_c;
          // mem is sampled before this edge's write lands: read-first
          if (read && in_range_c) begin
            dataout_d = mem[address];
          end
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == RUN);
  end

  // Storage array; init sweep and normal writes share the single port
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

endmodule
